pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It generates the `go` (hold) and `clear` (bubble) controls consumed by the PC register and the IF_ID, ID_EXE, EXE_MEM and MEM_WB buffers. It also implements the syscall halt/resume state machine and three 32-bit performance counters for the display. It sits beside the datapath and reads instruction words already carried by the pipeline buffers.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/perf_counter.sv | 26 ++
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic:
// opcode constants, instruction field positions and the halt/resume FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_LW = 6'h23;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2
    } state_t;

    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter; advances by one on each clock with inc high.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Event count, wraps silently at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stall, branch flush,
// syscall halt/resume FSM and cycle/stall/flush performance counters.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int         CNT_W = 32,
    parameter logic [5:0] LW_OP = OP_LW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      exe_instr,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             id_exe_go,
    output logic             exe_mem_go,
    output logic             mem_wb_go,
    output logic             if_id_clear,
    output logic             id_exe_clear,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t r_state;
    state_t w_next_state;
    logic   r_resume_q;
    logic   r_halted;

    logic   w_resume_rise;
    logic   w_load_use;
    logic   w_freeze;
    logic   w_flush;
    logic   w_stall;
    logic   w_cycle_inc;
    logic [4:0] w_exe_rt;

    assign w_resume_rise = resume & ~r_resume_q;
    assign w_exe_rt      = rt_of(exe_instr);

    // Conservative: a match on rt counts even if the ID instruction never reads rt.
    assign w_load_use = (op_of(exe_instr) == LW_OP) && (w_exe_rt != 5'd0) &&
                        ((w_exe_rt == rs_of(id_instr)) || (w_exe_rt == rt_of(id_instr)));

    assign w_freeze    = ((r_state == RUN) && halt_req) || (r_state == HALT);
    assign w_flush     = ~w_freeze & branch_taken;
    assign w_stall     = ~w_freeze & ~branch_taken & w_load_use;
    assign w_cycle_inc = ~w_freeze;

    // FSM state, resume edge detector and registered halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_resume_q <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_resume_q <= resume;
            r_halted   <= (w_next_state == HALT);
        end
    end

    // Next-state logic; halt_req is ignored in RESUME so the syscall can retire.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     w_next_state = halt_req ? HALT : RUN;
            HALT:    w_next_state = w_resume_rise ? RESUME : HALT;
            RESUME:  w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // Priority decode of buffer load enables and bubble inserts.
    always_comb begin
        pc_go        = 1'b1;
        if_id_go     = 1'b1;
        id_exe_go    = 1'b1;
        exe_mem_go   = 1'b1;
        mem_wb_go    = 1'b1;
        if_id_clear  = 1'b0;
        id_exe_clear = 1'b0;
        if (!rst_n || w_freeze) begin
            pc_go      = 1'b0;
            if_id_go   = 1'b0;
            id_exe_go  = 1'b0;
            exe_mem_go = 1'b0;
            mem_wb_go  = 1'b0;
        end else if (w_flush) begin
            if_id_clear  = 1'b1;
            id_exe_clear = 1'b1;
        end else if (w_stall) begin
            pc_go        = 1'b0;
            if_id_go     = 1'b0;
            id_exe_clear = 1'b1;
        end else begin
            pc_go = 1'b1;
        end
    end

    assign halted = r_halted;

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cycle_inc),
        .count (cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against a 32-bit and a 4-bit instance.
module tb_pipeline_ctrl;

    typedef struct {
        string       tag;
        logic [4:0]  go;
        logic [1:0]  clr;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] fls;
    } exp_t;

    localparam logic [4:0]  GO_ALL   = 5'b11111;
    localparam logic [4:0]  GO_STALL = 5'b00111;
    localparam logic [4:0]  GO_NONE  = 5'b00000;
    localparam logic [1:0]  CLR_NONE = 2'b00;
    localparam logic [1:0]  CLR_ID   = 2'b01;
    localparam logic [1:0]  CLR_BOTH = 2'b11;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic [31:0] exe_instr = 32'h0;
    logic        branch_taken = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic        pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go;
    logic        if_id_clear, id_exe_clear, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    logic        pc_go4, if_id_go4, id_exe_go4, exe_mem_go4, mem_wb_go4;
    logic        if_id_clear4, id_exe_clear4, halted4;
    logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .exe_instr(exe_instr),
        .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
        .pc_go(pc_go), .if_id_go(if_id_go), .id_exe_go(id_exe_go),
        .exe_mem_go(exe_mem_go), .mem_wb_go(mem_wb_go),
        .if_id_clear(if_id_clear), .id_exe_clear(id_exe_clear), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .exe_instr(exe_instr),
        .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
        .pc_go(pc_go4), .if_id_go(if_id_go4), .id_exe_go(id_exe_go4),
        .exe_mem_go(exe_mem_go4), .mem_wb_go(mem_wb_go4),
        .if_id_clear(if_id_clear4), .id_exe_clear(id_exe_clear4), .halted(halted4),
        .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "go",     {27'd0, pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go}, {27'd0, e.go});
            chk(e.tag, "clear",  {30'd0, if_id_clear, id_exe_clear}, {30'd0, e.clr});
            chk(e.tag, "halted", {31'd0, halted}, {31'd0, e.halted});
            chk(e.tag, "cycle",  cycle_cnt, e.cyc);
            chk(e.tag, "stall",  stall_cnt, e.stl);
            chk(e.tag, "flush",  flush_cnt, e.fls);
            chk(e.tag, "go4",    {27'd0, pc_go4, if_id_go4, id_exe_go4, exe_mem_go4, mem_wb_go4}, {27'd0, e.go});
            chk(e.tag, "clear4", {30'd0, if_id_clear4, id_exe_clear4}, {30'd0, e.clr});
            chk(e.tag, "halted4", {31'd0, halted4}, {31'd0, e.halted});
            chk(e.tag, "cycle4", {28'd0, cycle_cnt4}, {28'd0, e.cyc[3:0]});
            chk(e.tag, "stall4", {28'd0, stall_cnt4}, {28'd0, e.stl[3:0]});
            chk(e.tag, "flush4", {28'd0, flush_cnt4}, {28'd0, e.fls[3:0]});
        end
    end

    task automatic step(input string tag, input logic rst, input logic [31:0] exe,
                        input logic [31:0] id, input logic br, input logic hr, input logic rs,
                        input logic [4:0] go, input logic [1:0] clr, input logic h,
                        input logic [31:0] c, input logic [31:0] s, input logic [31:0] f);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        exe_instr    = exe;
        id_instr     = id;
        branch_taken = br;
        halt_req     = hr;
        resume       = rs;
        e.tag = tag; e.go = go; e.clr = clr; e.halted = h;
        e.cyc = c; e.stl = s; e.fls = f;
        q.push_back(e);
    endtask

    initial begin
        step("reset",       1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_NONE,  CLR_NONE, 1'b0, 32'd0, 32'd0, 32'd0);
        step("run0",        1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_ALL,   CLR_NONE, 1'b0, 32'd0, 32'd0, 32'd0);
        step("loaduse_rs",  1'b1, 32'h8C08_0000, 32'h0109_4020, 1'b0, 1'b0, 1'b0, GO_STALL, CLR_ID, 1'b0, 32'd1, 32'd0, 32'd0);
        step("after_stall", 1'b1, NOP, 32'h0109_4020, 1'b0, 1'b0, 1'b0, GO_ALL, CLR_NONE, 1'b0, 32'd2, 32'd1, 32'd0);
        step("zero_dest",   1'b1, 32'h8C00_0000, 32'h0000_1020, 1'b0, 1'b0, 1'b0, GO_ALL, CLR_NONE, 1'b0, 32'd3, 32'd1, 32'd0);
        step("br_loaduse",  1'b1, 32'h8C08_0000, 32'h0109_4020, 1'b1, 1'b0, 1'b0, GO_ALL, CLR_BOTH, 1'b0, 32'd4, 32'd1, 32'd0);
        step("loaduse_rt",  1'b1, 32'h8C09_0000, 32'h0109_4020, 1'b0, 1'b0, 1'b0, GO_STALL, CLR_ID, 1'b0, 32'd5, 32'd1, 32'd1);
        step("run1",        1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_ALL,   CLR_NONE, 1'b0, 32'd6, 32'd2, 32'd1);
        step("halt_req",    1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0, GO_NONE,  CLR_NONE, 1'b0, 32'd7, 32'd2, 32'd1);
        step("halted",      1'b1, NOP, NOP, 1'b1, 1'b1, 1'b0, GO_NONE,  CLR_NONE, 1'b1, 32'd7, 32'd2, 32'd1);
        step("resume_edge", 1'b1, NOP, NOP, 1'b0, 1'b1, 1'b1, GO_NONE,  CLR_NONE, 1'b1, 32'd7, 32'd2, 32'd1);
        step("resume_st",   1'b1, NOP, NOP, 1'b0, 1'b1, 1'b1, GO_ALL,   CLR_NONE, 1'b0, 32'd7, 32'd2, 32'd1);
        step("resume_h2",   1'b1, NOP, NOP, 1'b0, 1'b0, 1'b1, GO_ALL,   CLR_NONE, 1'b0, 32'd8, 32'd2, 32'd1);
        step("resume_h3",   1'b1, NOP, NOP, 1'b0, 1'b0, 1'b1, GO_ALL,   CLR_NONE, 1'b0, 32'd9, 32'd2, 32'd1);
        step("resume_h4",   1'b1, NOP, NOP, 1'b0, 1'b0, 1'b1, GO_ALL,   CLR_NONE, 1'b0, 32'd10, 32'd2, 32'd1);
        step("resume_low",  1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_ALL,   CLR_NONE, 1'b0, 32'd11, 32'd2, 32'd1);

        step("reset2",      1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_NONE,  CLR_NONE, 1'b0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            step("wrap_run", 1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_ALL, CLR_NONE, 1'b0, 32'(i), 32'd0, 32'd0);
        end
        step("halt_wrap",   1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0, GO_NONE,  CLR_NONE, 1'b0, 32'h10, 32'd0, 32'd0);
        step("halt_hold",   1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_NONE,  CLR_NONE, 1'b1, 32'h10, 32'd0, 32'd0);
        step("rst_in_halt", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_NONE,  CLR_NONE, 1'b0, 32'd0, 32'd0, 32'd0);
        step("post_rst",    1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, GO_ALL,   CLR_NONE, 1'b0, 32'd0, 32'd0, 32'd0);
        step("post_rst2",   1'b1, 32'h8C08_0000, 32'h0100_0020, 1'b0, 1'b0, 1'b0, GO_STALL, CLR_ID, 1'b0, 32'd1, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        chk("drain", "queue_left", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
